// File: rtl/vc_sched_pkg.sv
// Shared encodings and widths for the VC0/VC1 -> D0/D1 weighted round-robin scheduler.
package vc_sched_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam int DEST_BIT = 4;
  localparam int CRED_W   = 4;
endpackage

// File: rtl/vc_credit_ctr.sv
// Single credit counter shared by both VCs: load a weight, decrement per pop, report zero.
module vc_credit_ctr
  import vc_sched_pkg::*;
(
  input  logic              clk,
  input  logic              reset_L,
  input  logic              load,
  input  logic              dec,
  input  logic [CRED_W-1:0] load_val,
  output logic [CRED_W-1:0] cnt,
  output logic              zero
);
  assign zero = (cnt == '0);

  // A load normally coincides with a pop, so that pop consumes one credit right away.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)        cnt <= '0;
    else if (load)       cnt <= dec ? load_val - CRED_W'(1) : load_val;
    else if (dec && !zero) cnt <= cnt - CRED_W'(1);
  end
endmodule

// File: rtl/vc_scheduler.sv
// Weighted round-robin pop arbiter from VC0/VC1 FIFOs into D0/D1 with one registered stage.
// Optional VC_SCHED_STATS_EN adds saturating pop/blocked counters.
module vc_scheduler
  import vc_sched_pkg::*;
#(
  parameter int WEIGHT_VC0 = 4,
  parameter int WEIGHT_VC1 = 1,
  parameter int DATA_W     = 6
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              active,
  input  logic              fifo_empty_vc0,
  input  logic              fifo_empty_vc1,
  input  logic [DATA_W-1:0] data_mux_0,
  input  logic [DATA_W-1:0] data_mux_1,
  input  logic              fifo_pause_d0,
  input  logic              fifo_pause_d1,
  output logic              pop_vc0,
  output logic              pop_vc1,
  output logic [DATA_W-1:0] data_d,
  output logic              push_d0,
  output logic              push_d1,
  output logic [1:0]        grant_vc
`ifdef VC_SCHED_STATS_EN
  ,
  output logic [15:0]       pop_cnt_vc0,
  output logic [15:0]       pop_cnt_vc1,
  output logic [15:0]       blocked_cnt
`endif
);
  localparam logic [CRED_W-1:0] W0 = CRED_W'(WEIGHT_VC0);
  localparam logic [CRED_W-1:0] W1 = CRED_W'(WEIGHT_VC1);

  state_t            state, nstate;
  logic              last_vc;
  logic [1:0]        paused, elig;
  logic              own_vc, go, sel, ld;
  logic              cred_zero;
  logic [CRED_W-1:0] cred;
  logic [DATA_W-1:0] head;

  assign paused[0] = data_mux_0[DEST_BIT] ? fifo_pause_d1 : fifo_pause_d0;
  assign paused[1] = data_mux_1[DEST_BIT] ? fifo_pause_d1 : fifo_pause_d0;
  // reset_L gates eligibility so the VC FIFOs are never popped while in reset.
  assign elig[0] = reset_L & active & ~fifo_empty_vc0 & ~paused[0];
  assign elig[1] = reset_L & active & ~fifo_empty_vc1 & ~paused[1];
  assign own_vc  = (state == GNT1);

  always_comb begin
    go     = 1'b0;
    sel    = 1'b0;
    ld     = 1'b0;
    nstate = state;
    if (active) begin
      if (state == IDLE) begin
        sel = (elig == 2'b11) ? ~last_vc : elig[1];
        go  = |elig;
        ld  = |elig;
      end else if (elig[own_vc] && !cred_zero) begin
        go  = 1'b1;
        sel = own_vc;
      end else if (elig[~own_vc]) begin
        go  = 1'b1;
        sel = ~own_vc;
        ld  = 1'b1;
      end else if (elig[own_vc]) begin
        go  = 1'b1;
        sel = own_vc;
        ld  = 1'b1;
      end else begin
        nstate = IDLE;
      end
      if (go) nstate = sel ? GNT1 : GNT0;
    end
  end

  assign pop_vc0  = go & ~sel;
  assign pop_vc1  = go & sel;
  assign head     = sel ? data_mux_1 : data_mux_0;
  assign grant_vc = state;

  vc_credit_ctr u_cred (
    .clk      (clk),
    .reset_L  (reset_L),
    .load     (ld),
    .dec      (go),
    .load_val (sel ? W1 : W0),
    .cnt      (cred),
    .zero     (cred_zero)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state   <= IDLE;
      last_vc <= 1'b1;
      data_d  <= '0;
      push_d0 <= 1'b0;
      push_d1 <= 1'b0;
    end else begin
      state   <= nstate;
      push_d0 <= go & ~head[DEST_BIT];
      push_d1 <= go & head[DEST_BIT];
      if (go) begin
        last_vc <= sel;
        data_d  <= head;
      end
    end
  end

`ifdef VC_SCHED_STATS_EN
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pop_cnt_vc0 <= '0;
      pop_cnt_vc1 <= '0;
      blocked_cnt <= '0;
    end else begin
      if (pop_vc0 && pop_cnt_vc0 != 16'hFFFF) pop_cnt_vc0 <= pop_cnt_vc0 + 16'd1;
      if (pop_vc1 && pop_cnt_vc1 != 16'hFFFF) pop_cnt_vc1 <= pop_cnt_vc1 + 16'd1;
      if ((~fifo_empty_vc0 | ~fifo_empty_vc1) && !go && blocked_cnt != 16'hFFFF)
        blocked_cnt <= blocked_cnt + 16'd1;
    end
  end
`endif
endmodule
